// File: rtl/timer_irq_src.sv
// -----------------------------------------------------------------------------
// timer_irq_src
//
// Memory-mapped machine timer that raises the timer interrupt request consumed
// by the core's interrupt controller.
//
//   Software programs a compare value over the peripheral bus. A free-running
//   counter is compared against it. On a match the counter restarts from zero
//   and a sticky pending bit is set. The pending bit, gated by the interrupt
//   enable, drives one bit of the interrupt flag vector. The trap handler
//   clears the pending bit by writing 1 to it (W1C).
//
// Register map (byte offsets, only addr_i[3:0] decoded):
//   0x0 CTRL   [0] EN  count enable      RW
//              [1] PEND sticky pending   W1C
//              [2] IE  interrupt enable  RW
//              [31:3] read as 0
//   0x4 VALUE  [31:0] counter            RW
//   0x8 CMP    [31:0] compare value      RW  (reset 32'hFFFF_FFFF)
//   0xC PRESC  [15:0] prescaler          RW  (only with TIMER_PRESCALE_EN)
//   Any other offset reads 0 and ignores writes.
//
// Build option:
//   TIMER_PRESCALE_EN  when defined, adds the PRESC register and a divider
//                      so that a tick occurs once every PRESC+1 enabled
//                      cycles. When undefined, every enabled cycle is a tick
//                      and offset 0xC behaves as an unmapped offset.
//
// Parameters:
//   INT_W    width of int_flag_o (must match the core's interrupt bus width)
//   INT_BIT  bit of int_flag_o driven by this timer; all other bits are 0
//
// Ports:
//   clk         in   1      clock
//   rst_n       in   1      synchronous, active-low reset
//   req_i       in   1      bus access request, one cycle per access
//   we_i        in   1      1 = write, 0 = read; sampled with req_i
//   addr_i      in   32     byte address, word aligned
//   data_i      in   32     write data
//   data_o      out  32     read data, valid while ack_o = 1, otherwise 0
//   ack_o       out  1      access complete, pulses one cycle after req_i
//   int_flag_o  out  INT_W  interrupt vector to the interrupt controller
// -----------------------------------------------------------------------------
module timer_irq_src #(
  parameter int INT_W   = 8,
  parameter int INT_BIT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_i,
  input  logic             we_i,
  input  logic [31:0]      addr_i,
  input  logic [31:0]      data_i,
  output logic [31:0]      data_o,
  output logic             ack_o,
  output logic [INT_W-1:0] int_flag_o
);

  // Register offsets within the decoded nibble of the address
  localparam logic [3:0] OFF_CTRL  = 4'h0;
  localparam logic [3:0] OFF_VALUE = 4'h4;
  localparam logic [3:0] OFF_CMP   = 4'h8;
  localparam logic [3:0] OFF_PRESC = 4'hC;

  // CTRL field positions
  localparam int CTRL_EN   = 0;
  localparam int CTRL_PEND = 1;
  localparam int CTRL_IE   = 2;

  localparam logic [31:0] CMP_RESET = 32'hFFFF_FFFF;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic        en_q;
  logic        pend_q;
  logic        ie_q;
  logic [31:0] value_q;
  logic [31:0] cmp_q;

  logic [31:0] rd_mux;
  logic [3:0]  offset;
  logic        wr_ctrl;
  logic        wr_value;
  logic        wr_cmp;
  logic        tick;
  logic        match;

  // Upper address bits are deliberately not decoded, so registers alias
  // every 16 bytes.
  logic unused_addr;
  assign unused_addr = ^addr_i[31:4];

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  assign offset   = addr_i[3:0];
  assign wr_ctrl  = req_i & we_i & (offset == OFF_CTRL);
  assign wr_value = req_i & we_i & (offset == OFF_VALUE);
  assign wr_cmp   = req_i & we_i & (offset == OFF_CMP);

  // ---------------------------------------------------------------------------
  // Tick generation
  // ---------------------------------------------------------------------------
`ifdef TIMER_PRESCALE_EN
  logic [15:0] presc_q;
  logic [15:0] div_q;
  logic        wr_presc;

  assign wr_presc = req_i & we_i & (offset == OFF_PRESC);

  // The tick is judged on the current EN, so a CTRL write that clears EN
  // still lets this cycle's tick happen.
  assign tick = en_q & (div_q == presc_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q <= '0;
    end else if (wr_presc) begin
      presc_q <= data_i[15:0];
    end
  end

  // The divider restarts whenever counting is stopped or the prescale value
  // changes, so a new PRESC always begins with a full period.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q <= '0;
    end else if (!en_q || wr_presc) begin
      div_q <= '0;
    end else if (div_q == presc_q) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + 16'd1;
    end
  end
`else
  assign tick = en_q;
`endif

  // Match uses the CMP value present before any same-cycle CMP write.
  assign match = tick & (value_q == cmp_q);

  // ---------------------------------------------------------------------------
  // Counter. A software write beats the tick in the same cycle. Wrapping
  // from FFFF_FFFF to 0 is a plain increment and raises nothing by itself.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value_q <= '0;
    end else if (wr_value) begin
      value_q <= data_i;
    end else if (match) begin
      value_q <= '0;
    end else if (tick) begin
      value_q <= value_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmp_q <= CMP_RESET;
    end else if (wr_cmp) begin
      cmp_q <= data_i;
    end
  end

  // ---------------------------------------------------------------------------
  // CTRL. A match outranks a W1C clear in the same cycle so an event that
  // arrives while software acknowledges the previous one is never lost.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en_q   <= 1'b0;
      ie_q   <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        en_q <= data_i[CTRL_EN];
        ie_q <= data_i[CTRL_IE];
      end
      if (match) begin
        pend_q <= 1'b1;
      end else if (wr_ctrl && data_i[CTRL_PEND]) begin
        pend_q <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux, built from register state before this cycle's updates
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_mux = '0;
    case (offset)
      OFF_CTRL:  rd_mux = {29'd0, ie_q, pend_q, en_q};
      OFF_VALUE: rd_mux = value_q;
      OFF_CMP:   rd_mux = cmp_q;
`ifdef TIMER_PRESCALE_EN
      OFF_PRESC: rd_mux = {16'd0, presc_q};
`endif
      default:   rd_mux = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Bus response: every request completes one cycle later. data_o is held at
  // zero except for the ack cycle of a read. Reset drops a request sampled
  // at the same edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ack_o  <= 1'b0;
      data_o <= '0;
    end else begin
      ack_o  <= req_i;
      data_o <= (req_i && !we_i) ? rd_mux : 32'd0;
    end
  end

  // ---------------------------------------------------------------------------
  // Interrupt output is decoded from registers only, so no bus input reaches
  // it combinationally.
  // ---------------------------------------------------------------------------
  always_comb begin
    int_flag_o          = '0;
    int_flag_o[INT_BIT] = pend_q & ie_q;
  end

endmodule

// File: tb/tb_timer_irq_src.sv
// -----------------------------------------------------------------------------
// tb_timer_irq_src
//
// Self-checking bench for timer_irq_src. A behavioural model of the register
// file runs in lock step with the DUT; every cycle the DUT's ack_o, data_o
// and int_flag_o are compared with the model's prediction. Directed sequences
// are followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_timer_irq_src;

  localparam int INT_W   = 8;
  localparam int INT_BIT = 0;

`ifdef TIMER_PRESCALE_EN
  localparam bit HAS_PRESC = 1'b1;
`else
  localparam bit HAS_PRESC = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic             req_i;
  logic             we_i;
  logic [31:0]      addr_i;
  logic [31:0]      data_i;
  logic [31:0]      data_o;
  logic             ack_o;
  logic [INT_W-1:0] int_flag_o;

  int n_checks = 0;
  int n_pass   = 0;

  timer_irq_src #(.INT_W(INT_W), .INT_BIT(INT_BIT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_i      (req_i),
    .we_i       (we_i),
    .addr_i     (addr_i),
    .data_i     (data_i),
    .data_o     (data_o),
    .ack_o      (ack_o),
    .int_flag_o (int_flag_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model state
  bit          m_en, m_pend, m_ie;
  logic [31:0] m_value, m_cmp;
  logic [15:0] m_presc, m_div;
  logic        exp_ack;
  logic [31:0] exp_data, exp_int;

  // Compare one observed value against its expectation
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, actual, expected, $time);
    else
      n_pass++;
  endtask

  function automatic logic [31:0] m_read(input logic [3:0] off);
    case (off)
      4'h0:    return {29'd0, m_ie, m_pend, m_en};
      4'h4:    return m_value;
      4'h8:    return m_cmp;
      4'hC:    return HAS_PRESC ? {16'd0, m_presc} : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // True when the coming edge will produce a compare match
  function automatic bit m_will_match();
    bit tk;
    tk = m_en && (!HAS_PRESC || m_div == m_presc);
    return tk && (m_value == m_cmp);
  endfunction

  // Advance the model by one clock edge with the given inputs
  task automatic model_step(input logic rst, input logic req, input logic we,
                            input logic [31:0] addr, input logic [31:0] data);
    logic [3:0]  off;
    bit          wr, tk, hit, np;
    logic [31:0] nv;
    logic [15:0] nd;
    if (!rst) begin
      m_en = 0; m_pend = 0; m_ie = 0;
      m_value = 32'd0; m_cmp = 32'hFFFF_FFFF;
      m_presc = 16'd0; m_div = 16'd0;
      exp_ack = 1'b0; exp_data = 32'd0;
    end else begin
      off      = addr[3:0];
      wr       = req && we;
      exp_ack  = req;
      exp_data = (req && !we) ? m_read(off) : 32'd0;
      tk  = m_en && (!HAS_PRESC || m_div == m_presc);
      hit = tk && (m_value == m_cmp);
      // Counting effects first
      nv = hit ? 32'd0 : (tk ? m_value + 32'd1 : m_value);
      np = m_pend || hit;
      if (!m_en || (wr && off == 4'hC) || m_div == m_presc) nd = 16'd0;
      else nd = m_div + 16'd1;
      // Then software effects, which override where the rules say so
      if (wr) begin
        case (off)
          4'h0: begin
            m_en = data[0];
            m_ie = data[2];
            if (data[1] && !hit) np = 0;
          end
          4'h4: nv = data;
          4'h8: m_cmp = data;
          4'hC: if (HAS_PRESC) m_presc = data[15:0];
          default: ;
        endcase
      end
      m_value = nv;
      m_pend  = np;
      m_div   = HAS_PRESC ? nd : 16'd0;
    end
    exp_int = (m_pend && m_ie) ? (32'd1 << INT_BIT) : 32'd0;
  endtask

  // Drive one cycle of inputs, advance the model, then check after the edge
  task automatic applyStimulus(input logic rst, input logic req, input logic we,
                               input logic [31:0] addr, input logic [31:0] data);
    rst_n  = rst;
    req_i  = req;
    we_i   = we;
    addr_i = addr;
    data_i = data;
    model_step(rst, req, we, addr, data);
    @(posedge clk);
    #1;
    checkOutput("ack_o",      {31'd0, ack_o},    {31'd0, exp_ack});
    checkOutput("data_o",     data_o,            exp_data);
    checkOutput("int_flag_o", 32'(int_flag_o),   exp_int);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    applyStimulus(1'b1, 1'b1, 1'b1, addr, data);
  endtask

  task automatic rd(input logic [31:0] addr);
    applyStimulus(1'b1, 1'b1, 1'b0, addr, 32'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  // Overall time bound so the run always ends
  initial begin
    #500us;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int waited;
    rst_n = 1'b0; req_i = 1'b0; we_i = 1'b0; addr_i = '0; data_i = '0;

    // Reset and read back reset values
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    rd(32'h0); rd(32'h4); rd(32'h8); rd(32'hC);
    idle(1);

    // Basic count to match with interrupt, then W1C clear
    wr(32'h8, 32'd5);
    wr(32'h0, 32'h5);
    for (int i = 0; i < 9; i++) rd(32'h4);
    rd(32'h0);
    wr(32'h0, 32'h7);
    rd(32'h0);
    idle(1);

    // IE=0 masks the output without clearing PEND
    wr(32'h0, 32'h2);
    wr(32'h4, 32'd0);
    wr(32'h8, 32'd3);
    wr(32'h0, 32'h1);
    idle(6);
    rd(32'h0);
    wr(32'h0, 32'h5);
    idle(2);

    // W1C in the same cycle as a match leaves PEND set
    wr(32'h0, 32'h2);
    wr(32'h4, 32'd0);
    wr(32'h8, 32'd2);
    wr(32'h0, 32'h5);
    waited = 0;
    while (!m_will_match() && waited < 50) begin idle(1); waited++; end
    checkOutput("match_wait", waited < 50 ? 32'd1 : 32'd0, 32'd1);
    wr(32'h0, 32'h7);
    rd(32'h0);

    // Wrap from FFFF_FFFF with CMP=0, then match on the next tick
    wr(32'h0, 32'h6);
    wr(32'h8, 32'd0);
    wr(32'h4, 32'hFFFF_FFFF);
    wr(32'h0, 32'h5);
    rd(32'h4); rd(32'h4); rd(32'h0); rd(32'h4);

    // Clearing EN still lets that cycle's tick happen
    wr(32'h8, 32'd100);
    idle(2);
    wr(32'h0, 32'h0);
    rd(32'h4); rd(32'h4);

    // Aliased address and offset 0xC handling
    wr(32'hABCD_0010, 32'h0000_0004);
    rd(32'h1230_0000);
    wr(32'h0000_000C, 32'hDEAD_0007);
    rd(32'hC);
    wr(32'h0000_000C, 32'd0);

    // Reset mid-count with PEND set and a read in flight
    wr(32'h8, 32'd4);
    wr(32'h4, 32'd0);
    wr(32'h0, 32'h5);
    waited = 0;
    while (!m_pend && waited < 50) begin idle(1); waited++; end
    checkOutput("pend_wait", waited < 50 ? 32'd1 : 32'd0, 32'd1);
    idle(2);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h4, 32'd0);
    rd(32'h0); rd(32'h4); rd(32'h8);

`ifdef TIMER_PRESCALE_EN
    // Prescaled counting: one tick every PRESC+1 cycles
    wr(32'hC, 32'd3);
    wr(32'h8, 32'd2);
    wr(32'h0, 32'h5);
    for (int i = 0; i < 14; i++) rd(32'h4);
    rd(32'h0);
    wr(32'h0, 32'h2);
`endif

    // Randomized phase
    for (int i = 0; i < 1500; i++) begin
      int          r, sel;
      logic [31:0] hi, d;
      logic [3:0]  off;
      r   = $urandom_range(0, 99);
      sel = $urandom_range(0, 3);
      off = 4'(sel * 4);
      hi  = $urandom & 32'hFFFF_FFF0;
      if (r < 2) begin
        applyStimulus(1'b0, $urandom_range(0, 1) == 1, 1'b0, hi, 32'd0);
      end else if (r < 40) begin
        idle(1);
      end else if (r < 65) begin
        rd(hi | {28'd0, off});
      end else begin
        case (sel)
          0: begin
            d = $urandom;
            d[0] = ($urandom_range(0, 9) < 7);
          end
          1: d = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 15)
                                              : 32'hFFFF_FFF0 + $urandom_range(0, 15);
          2: d = ($urandom_range(0, 3) != 0) ? $urandom_range(0, 15) : 32'hFFFF_FFFF;
          default: d = ($urandom & 32'hFFFF_0000) | $urandom_range(0, 3);
        endcase
        wr(hi | {28'd0, off}, d);
      end
    end

    idle(2);
    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
